cnu_min_sched: RTL
==================

CNU_MIN_SCHED -- requirements
Module: cnu_min_sched

Interface
REQ-001 Parameter W, default 6, LLR word width: 1 sign bit plus W-1 magnitude bits.
REQ-002 Parameter LAT, default 5, min-finder latency in cycles from mf_x to registered mf_min1/mf_min2/mf_idx.
REQ-003 Parameter ROWS_W, default 8, row-address width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  run request; sampled only in IDLE.
REQ-007 num_rows  in  ROWS_W  number of check rows to process, latched on an accepted start.
REQ-008 busy  out  1  high whenever state is not IDLE.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 mem_re  out  1  row-memory read enable.
REQ-011 mem_addr  out  ROWS_W  row-memory read address.
REQ-012 mem_rdata  in  32*W  row data, valid one cycle after mem_re; lane i occupies bits [i*W +: W], sign in the MSB.
REQ-013 mf_x  out  32*(W-1)  magnitudes to the 32-input min-finder; lane i occupies [i*(W-1) +: W-1].
REQ-014 mf_min1  in  W-1  min-finder smallest magnitude.
REQ-015 mf_min2  in  W-1  min-finder second-smallest magnitude.
REQ-016 mf_idx  in  5  min-finder lane index of min1.
REQ-017 res_we  out  1  result write strobe.
REQ-018 res_addr  out  ROWS_W  row of the current result.
REQ-019 res_min1  out  W-1  min1 of the row.
REQ-020 res_min2  out  W-1  min2 of the row.
REQ-021 res_idx  out  5  index of min1.
REQ-022 res_sign  out  1  XOR of all 32 sign bits of the row.

Function
REQ-023 The FSM shall have states IDLE, ISSUE, DRAIN, DONE; reset enters IDLE.
REQ-024 IDLE with start=1 shall latch num_rows and go to ISSUE if num_rows>0, otherwise go directly to DONE.
REQ-025 start shall be ignored in every state other than IDLE.
REQ-026 ISSUE shall assert mem_re every cycle with mem_addr = 0,1,...,num_rows-1, one row per cycle with no gaps, then go to DRAIN.
REQ-027 mf_x shall be the combinational sign-stripped mem_rdata; res_sign shall be computed in the same cycle.
REQ-028 A (LAT+1)-deep valid/address/sign shift register shall track in-flight rows; res_we for row r shall assert exactly 1+LAT cycles after its mem_re cycle.
REQ-029 res_min1, res_min2 and res_idx shall pass mf_min1, mf_min2 and mf_idx unchanged while res_we=1; the min-finder's tie rule (lower lane wins) applies.
REQ-030 DRAIN shall last until the tracker is empty, then go to DONE; DONE shall assert done for one cycle and return to IDLE.
REQ-031 With start sampled at cycle 0 and N=num_rows>0: mem_re in cycles 1..N; res_we in cycles LAT+2..LAT+N+1; done in cycle LAT+N+2. With N=0: done in cycle 1 and no mem_re.
REQ-032 res_we shall never assert for a row not issued in the current run.

Reset
REQ-033 While rst=0, all outputs and the tracker shall be 0 and the state IDLE, regardless of clk.
REQ-034 Reset mid-run shall discard in-flight rows: no res_we and no done shall follow; the next start shall run normally.

Configuration
REQ-035 With CNU_SCHED_STATS_EN defined, an added output stat_cycles[15:0] shall count busy cycles of the last run (saturating at 0xFFFF, cleared on accepted start, held after done, reset to 0).
REQ-036 Without CNU_SCHED_STATS_EN, the port and counter shall be absent and all other behaviour identical.

Verification
REQ-037 LAT=5, N=1; lanes=31 except lane7=3, lane20=9; sign set only in lane4 -> cycle 7: res_we=1, addr=0, min1=3, min2=9, idx=7, sign=1; done in cycle 8.
REQ-038 N=4 -> mem_re cycles 1-4, res_we cycles 7-10 with addr 0-3, done in cycle 11, busy cycles 1-11.
REQ-039 N=0 -> done in cycle 1, busy in cycle 1 only, no mem_re, no res_we.
REQ-040 start re-pulsed in cycle 3 of an N=4 run -> ignored; identical trace to REQ-038.
REQ-041 rst=0 in cycle 5 of an N=4 run -> outputs 0 at once; no res_we or done afterwards; new start with N=1 gives REQ-037 timing.
REQ-042 Lanes 2 and 10 both magnitude 4, all others 31 -> min1=4, min2=4, idx=2; with STATS_EN, stat_cycles=8 after N=1.

Source files
------------

// File: rtl/cnu_min_sched_if.sv
// cnu_min_sched_if: bundle of run-control, row-memory, min-finder and result signals
// for cnu_min_sched.
// Parameters: W (LLR width), ROWS_W (row address width).
// Modports: master = scheduler side, slave = environment side (memory, min-finder, sink).
// Optional: CNU_SCHED_STATS_EN adds stat_cycles.
interface cnu_min_sched_if #(
    parameter int W      = 6,
    parameter int ROWS_W = 8
);
    logic                  start;
    logic [ROWS_W-1:0]     num_rows;
    logic                  busy;
    logic                  done;
    logic                  mem_re;
    logic [ROWS_W-1:0]     mem_addr;
    logic [32*W-1:0]       mem_rdata;
    logic [32*(W-1)-1:0]   mf_x;
    logic [W-2:0]          mf_min1;
    logic [W-2:0]          mf_min2;
    logic [4:0]            mf_idx;
    logic                  res_we;
    logic [ROWS_W-1:0]     res_addr;
    logic [W-2:0]          res_min1;
    logic [W-2:0]          res_min2;
    logic [4:0]            res_idx;
    logic                  res_sign;
`ifdef CNU_SCHED_STATS_EN
    logic [15:0]           stat_cycles;
`endif

    modport master (
`ifdef CNU_SCHED_STATS_EN
        output stat_cycles,
`endif
        input  start, num_rows, mem_rdata, mf_min1, mf_min2, mf_idx,
        output busy, done, mem_re, mem_addr, mf_x,
        output res_we, res_addr, res_min1, res_min2, res_idx, res_sign
    );

    modport slave (
`ifdef CNU_SCHED_STATS_EN
        input  stat_cycles,
`endif
        output start, num_rows, mem_rdata, mf_min1, mf_min2, mf_idx,
        input  busy, done, mem_re, mem_addr, mf_x,
        input  res_we, res_addr, res_min1, res_min2, res_idx, res_sign
    );
endinterface

// File: rtl/cnu_min_sched.sv
// cnu_min_sched: streams check rows from memory into an external 32-input min-finder
// and emits one result (min1, min2, idx, sign parity) per row.
// Parameters: W (LLR width, sign + W-1 magnitude), LAT (min-finder latency, >= 1),
//             ROWS_W (row address width).
// Ports: clk, rst (asynchronous, active-low), bus (cnu_min_sched_if.master):
//   start/num_rows/busy/done    run control
//   mem_re/mem_addr/mem_rdata   row memory, read data valid one cycle after mem_re
//   mf_x/mf_min1/mf_min2/mf_idx external min-finder
//   res_we/res_addr/res_min1/res_min2/res_idx/res_sign  per-row result
// Optional: define CNU_SCHED_STATS_EN to add bus.stat_cycles (busy cycles of the last run).
module cnu_min_sched #(
    parameter int W      = 6,
    parameter int LAT    = 5,
    parameter int ROWS_W = 8
) (
    input logic             clk,
    input logic             rst,
    cnu_min_sched_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ROWS_W-1:0] ONE = 1;

    state_t            state, state_nx;
    logic [ROWS_W-1:0] rows;
    logic [ROWS_W-1:0] cnt;
    logic [LAT:0]      vld;
    logic [ROWS_W-1:0] adr [0:LAT];
    logic [LAT:1]      sgn;
    logic [31:0]       lane_sign;
    logic              accept;

    assign accept = (state == IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rows  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                rows <= bus.num_rows;
            cnt <= (state == ISSUE) ? cnt + ONE : '0;
        end
    end

    always_comb begin
        state_nx     = state;
        bus.busy     = state != IDLE;
        bus.done     = state == DONE;
        bus.mem_re   = state == ISSUE;
        bus.mem_addr = (state == ISSUE) ? cnt : '0;
        case (state)
            IDLE:    if (bus.start) state_nx = (bus.num_rows != '0) ? ISSUE : DONE;
            ISSUE:   if (cnt == rows - ONE) state_nx = DRAIN;
            // Leave once nothing but the final stage remains, so done lands
            // the cycle after the last res_we.
            DRAIN:   if (vld[LAT-1:0] == '0) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Read data for the row in stage 0 is on mem_rdata now; gating with vld[0]
    // keeps mf_x quiet between rows and during reset.
    genvar i;
    for (i = 0; i < 32; i++) begin : g_lane
        assign bus.mf_x[i*(W-1) +: W-1] = vld[0] ? bus.mem_rdata[i*W +: W-1] : '0;
        assign lane_sign[i]             = bus.mem_rdata[i*W + W-1];
    end

    // Row tracker: stage k holds the row read k+1 cycles ago. The sign parity
    // only exists once data returns, so its chain starts at stage 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            sgn <= '0;
            for (int k = 0; k <= LAT; k++)
                adr[k] <= '0;
        end else begin
            vld    <= {vld[LAT-1:0], bus.mem_re};
            adr[0] <= bus.mem_addr;
            for (int k = 1; k <= LAT; k++)
                adr[k] <= adr[k-1];
            sgn[1] <= vld[0] & ^lane_sign;
            for (int k = 2; k <= LAT; k++)
                sgn[k] <= sgn[k-1];
        end
    end

    assign bus.res_we   = vld[LAT];
    assign bus.res_addr = vld[LAT] ? adr[LAT] : '0;
    assign bus.res_min1 = vld[LAT] ? bus.mf_min1 : '0;
    assign bus.res_min2 = vld[LAT] ? bus.mf_min2 : '0;
    assign bus.res_idx  = vld[LAT] ? bus.mf_idx : '0;
    assign bus.res_sign = sgn[LAT];

`ifdef CNU_SCHED_STATS_EN
    logic [15:0] stat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stat <= '0;
        else if (accept)
            stat <= '0;
        else if (bus.busy && stat != 16'hFFFF)
            stat <= stat + 16'd1;
    end

    assign bus.stat_cycles = stat;
`endif
endmodule
